// File: rtl/watch_ctrl_pkg.sv
// Shared types and constants for the watch control unit: adjust-state encoding,
// per-state digit-select codes, arbitrated action codes and UART command bytes.
package watch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_ADJ_SEC  = 2'd1,
    ST_ADJ_MIN  = 2'd2,
    ST_ADJ_HOUR = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_MODE  = 3'd1,
    ACT_CLEAR = 3'd2,
    ACT_UP    = 3'd3,
    ACT_DOWN  = 3'd4,
    ACT_RUN   = 3'd5,
    ACT_ERR   = 3'd6
  } act_t;

  localparam logic [3:0] SEL_RUN      = 4'b0000;
  localparam logic [3:0] SEL_ADJ_SEC  = 4'b1000;
  localparam logic [3:0] SEL_ADJ_MIN  = 4'b0100;
  localparam logic [3:0] SEL_ADJ_HOUR = 4'b0010;

  localparam logic [7:0] CMD_MODE  = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
  localparam logic [7:0] CMD_UP    = 8'h55;  // 'U'
  localparam logic [7:0] CMD_DOWN  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'

  function automatic logic [3:0] state_sel(input state_t s);
    case (s)
      ST_ADJ_SEC:  state_sel = SEL_ADJ_SEC;
      ST_ADJ_MIN:  state_sel = SEL_ADJ_MIN;
      ST_ADJ_HOUR: state_sel = SEL_ADJ_HOUR;
      default:     state_sel = SEL_RUN;
    endcase
  endfunction

  function automatic state_t mode_next(input state_t s);
    case (s)
      ST_RUN:      mode_next = ST_ADJ_SEC;
      ST_ADJ_SEC:  mode_next = ST_ADJ_MIN;
      ST_ADJ_MIN:  mode_next = ST_ADJ_HOUR;
      default:     mode_next = ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detect plus hold/auto-repeat generator for one debounced button level.
// Ticks are counted only while the level was already high on the previous cycle.
module btn_repeat #(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic i_tick,
  input  logic inhibit,
  output logic edge_act,
  output logic rep_act
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int REP_W  = $clog2(REPEAT_TICKS + 1);

  logic              level_p1;
  logic [HOLD_W-1:0] hold_cnt_p1;
  logic [REP_W-1:0]  rep_cnt_p1;
  logic              held;
  logic              hold_done;
  logic              hold_fire;
  logic              rep_fire;

  // stage p0: combinational edge / hold / repeat decisions
  assign held      = level & level_p1 & ~inhibit;
  assign hold_done = (hold_cnt_p1 == HOLD_W'(HOLD_TICKS));
  assign hold_fire = held & i_tick & ~hold_done & (hold_cnt_p1 == HOLD_W'(HOLD_TICKS - 1));
  assign rep_fire  = held & i_tick & hold_done & (rep_cnt_p1 == REP_W'(REPEAT_TICKS - 1));
  assign edge_act  = level & ~level_p1 & ~inhibit;
  assign rep_act   = hold_fire | rep_fire;

  // stage p1: level history and saturating counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_p1    <= 1'b0;
      hold_cnt_p1 <= '0;
      rep_cnt_p1  <= '0;
    end else begin
      level_p1 <= level;
      if (!held) begin
        hold_cnt_p1 <= '0;
        rep_cnt_p1  <= '0;
      end else if (i_tick) begin
        if (!hold_done)    hold_cnt_p1 <= hold_cnt_p1 + 1'b1;
        else if (rep_fire) rep_cnt_p1  <= '0;
        else               rep_cnt_p1  <= rep_cnt_p1 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// Watch control unit: arbitrates buttons and UART commands into one action per
// cycle, sequences the adjust FSM and drives registered pulses to the datapath.
module watch_ctrl
  import watch_ctrl_pkg::*;
#(
  parameter int HOLD_TICKS    = 500,
  parameter int REPEAT_TICKS  = 100,
  parameter int TIMEOUT_TICKS = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       btn_mode,
  input  logic       btn_clear,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [3:0] adjust_digit_sel,
  output logic       clear,
  output logic       inc,
  output logic       dec,
  output logic       cmd_err
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  state_t          state_p1;
  state_t          state_p0;
  act_t            act_p0;
  logic            btn_act;
  logic [TO_W-1:0] to_cnt_p1;
  logic [TO_W-1:0] to_cnt_p0;
  logic            to_rst;
  logic            to_hit;
  logic            up_edge, up_rep, dn_edge, dn_rep;
  logic            both_held;

  assign both_held = btn_up & btn_down;

  btn_repeat #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_up (
    .clk(clk), .rst(rst), .level(btn_up), .i_tick(i_tick), .inhibit(both_held),
    .edge_act(up_edge), .rep_act(up_rep)
  );

  btn_repeat #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_down (
    .clk(clk), .rst(rst), .level(btn_down), .i_tick(i_tick), .inhibit(both_held),
    .edge_act(dn_edge), .rep_act(dn_rep)
  );

  // stage p0: priority arbitration; a command pops only when no button acts
  always_comb begin
    act_p0 = ACT_NONE;
    if (btn_clear)    act_p0 = ACT_CLEAR;
    else if (btn_mode) act_p0 = ACT_MODE;
    else if (up_edge)  act_p0 = ACT_UP;
    else if (dn_edge)  act_p0 = ACT_DOWN;
    else if (up_rep)   act_p0 = ACT_UP;
    else if (dn_rep)   act_p0 = ACT_DOWN;
    btn_act   = (act_p0 != ACT_NONE);
    cmd_ready = rst & ~btn_act;
    if (cmd_valid && cmd_ready) begin
      case (cmd_data)
        CMD_MODE:  act_p0 = ACT_MODE;
        CMD_CLEAR: act_p0 = ACT_CLEAR;
        CMD_UP:    act_p0 = ACT_UP;
        CMD_DOWN:  act_p0 = ACT_DOWN;
        CMD_RUN:   act_p0 = ACT_RUN;
        default:   act_p0 = ACT_ERR;
      endcase
    end
  end

  // Inactivity timer: a rejected byte is not an action and does not restart it.
  always_comb begin
    to_rst = ((act_p0 != ACT_NONE) && (act_p0 != ACT_ERR)) | btn_up | btn_down;
    to_hit = (state_p1 != ST_RUN) & ~to_rst & i_tick &
             (to_cnt_p1 == TO_W'(TIMEOUT_TICKS - 1));
    to_cnt_p0 = to_cnt_p1;
    if ((state_p1 == ST_RUN) || to_rst || to_hit)
      to_cnt_p0 = '0;
    else if (i_tick && (to_cnt_p1 != TO_W'(TIMEOUT_TICKS)))
      to_cnt_p0 = to_cnt_p1 + 1'b1;
  end

  always_comb begin
    state_p0 = state_p1;
    case (act_p0)
      ACT_MODE: state_p0 = mode_next(state_p1);
      ACT_RUN:  state_p0 = ST_RUN;
      default:  state_p0 = state_p1;
    endcase
    if (to_hit) state_p0 = ST_RUN;
  end

  // stage p1: registered state, select decode and datapath pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p1         <= ST_RUN;
      to_cnt_p1        <= '0;
      adjust_digit_sel <= SEL_RUN;
      clear            <= 1'b0;
      inc              <= 1'b0;
      dec              <= 1'b0;
      cmd_err          <= 1'b0;
    end else begin
      state_p1         <= state_p0;
      to_cnt_p1        <= to_cnt_p0;
      adjust_digit_sel <= state_sel(state_p0);
      clear            <= (act_p0 == ACT_CLEAR);
      inc              <= (act_p0 == ACT_UP)   && (state_p1 != ST_RUN);
      dec              <= (act_p0 == ACT_DOWN) && (state_p1 != ST_RUN);
      cmd_err          <= (act_p0 == ACT_ERR);
    end
  end

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed bench for watch_ctrl with HOLD_TICKS=4, REPEAT_TICKS=2,
// TIMEOUT_TICKS=20 and i_tick asserted every cycle.
module tb_watch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick;
  logic       btn_mode, btn_clear, btn_up, btn_down;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [3:0] adjust_digit_sel;
  logic       clear, inc, dec, cmd_err;

  int n_vec = 0;
  int n_err = 0;

  watch_ctrl #(.HOLD_TICKS(4), .REPEAT_TICKS(2), .TIMEOUT_TICKS(20)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick),
    .btn_mode(btn_mode), .btn_clear(btn_clear), .btn_up(btn_up), .btn_down(btn_down),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .adjust_digit_sel(adjust_digit_sel), .clear(clear), .inc(inc), .dec(dec),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_tick = 1'b1; btn_mode = 1'b0; btn_clear = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h4D;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
    cyc(); cyc();
    n_vec++;
    if (adjust_digit_sel !== 4'b0000) begin n_err++; $display("FAIL reset_sel got=%b exp=0000", adjust_digit_sel); end
    n_vec++;
    if ({clear, inc, dec, cmd_err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_pulses got=%b exp=0000", {clear, inc, dec, cmd_err});
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    cyc();
    n_vec++;
    if (adjust_digit_sel !== 4'b0000) begin n_err++; $display("FAIL reset_release_sel got=%b exp=0000", adjust_digit_sel); end
  endtask

  task automatic test_mode();
    logic [3:0] exp_sel [4];
    exp_sel = '{4'b1000, 4'b0100, 4'b0010, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      btn_mode = 1'b1;
      cyc();
      btn_mode = 1'b0;
      n_vec++;
      if (adjust_digit_sel !== exp_sel[i]) begin
        n_err++; $display("FAIL mode_step%0d got=%b exp=%b", i, adjust_digit_sel, exp_sel[i]);
      end
    end
  endtask

  task automatic test_hold_up();
    logic exp_inc;
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    n_vec++;
    if (adjust_digit_sel !== 4'b1000) begin n_err++; $display("FAIL hold_enter_sec got=%b exp=1000", adjust_digit_sel); end
    btn_up = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 10) btn_up = 1'b0;
      exp_inc = (k == 1) || (k == 5) || (k == 7) || (k == 9);
      n_vec++;
      if (inc !== exp_inc || dec !== 1'b0) begin
        n_err++; $display("FAIL hold_up_k%0d inc/dec got=%b%b exp=%b0", k, inc, dec, exp_inc);
      end
    end
    n_vec++;
    if (adjust_digit_sel !== 4'b1000) begin n_err++; $display("FAIL hold_up_state got=%b exp=1000", adjust_digit_sel); end
    cmd_valid = 1'b1; cmd_data = 8'h52;
    cyc();
    cmd_valid = 1'b0;
    n_vec++;
    if (adjust_digit_sel !== 4'b0000) begin n_err++; $display("FAIL cmd_return got=%b exp=0000", adjust_digit_sel); end
  endtask

  task automatic test_commands();
    cmd_valid = 1'b1; cmd_data = 8'h55;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL cmd_u_ready got=%b exp=1", cmd_ready); end
    cyc();
    n_vec++;
    if (inc !== 1'b0 || adjust_digit_sel !== 4'b0000) begin
      n_err++; $display("FAIL cmd_u_in_run inc=%b sel=%b exp inc=0 sel=0000", inc, adjust_digit_sel);
    end
    cmd_data = 8'h4D;
    cyc();
    n_vec++;
    if (adjust_digit_sel !== 4'b1000) begin n_err++; $display("FAIL cmd_m got=%b exp=1000", adjust_digit_sel); end
    cmd_data = 8'h44;
    cyc();
    n_vec++;
    if (dec !== 1'b1 || inc !== 1'b0) begin n_err++; $display("FAIL cmd_d dec/inc got=%b%b exp=10", dec, inc); end
    cmd_data = 8'h7A;
    cyc();
    n_vec++;
    if (cmd_err !== 1'b1 || dec !== 1'b0 || adjust_digit_sel !== 4'b1000) begin
      n_err++; $display("FAIL cmd_bad err=%b dec=%b sel=%b exp err=1 dec=0 sel=1000", cmd_err, dec, adjust_digit_sel);
    end
    cmd_data = 8'h43;
    cyc();
    n_vec++;
    if (clear !== 1'b1 || cmd_err !== 1'b0) begin
      n_err++; $display("FAIL cmd_c clear=%b err=%b exp clear=1 err=0", clear, cmd_err);
    end
    cmd_data = 8'h52;
    cyc();
    cmd_valid = 1'b0;
    n_vec++;
    if (adjust_digit_sel !== 4'b0000 || clear !== 1'b0) begin
      n_err++; $display("FAIL cmd_r sel=%b clear=%b exp sel=0000 clear=0", adjust_digit_sel, clear);
    end
    cyc();
    n_vec++;
    if ({clear, inc, dec, cmd_err} !== 4'b0000) begin
      n_err++; $display("FAIL cmd_idle got=%b exp=0000", {clear, inc, dec, cmd_err});
    end
  endtask

  task automatic test_clear_vs_cmd();
    btn_clear = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h4D;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL clr_block_ready got=%b exp=0", cmd_ready); end
    cyc();
    btn_clear = 1'b0;
    n_vec++;
    if (clear !== 1'b1 || adjust_digit_sel !== 4'b0000) begin
      n_err++; $display("FAIL clr_pulse clear=%b sel=%b exp clear=1 sel=0000", clear, adjust_digit_sel);
    end
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL clr_next_ready got=%b exp=1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0;
    n_vec++;
    if (adjust_digit_sel !== 4'b1000 || clear !== 1'b0) begin
      n_err++; $display("FAIL clr_cmd_m sel=%b clear=%b exp sel=1000 clear=0", adjust_digit_sel, clear);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_sel;
    logic       exp_dec;
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    n_vec++;
    if (adjust_digit_sel !== 4'b0100) begin n_err++; $display("FAIL to_enter_min got=%b exp=0100", adjust_digit_sel); end
    for (int k = 1; k <= 21; k++) begin
      cyc();
      exp_sel = (k < 20) ? 4'b0100 : 4'b0000;
      n_vec++;
      if (adjust_digit_sel !== exp_sel) begin
        n_err++; $display("FAIL timeout_k%0d got=%b exp=%b", k, adjust_digit_sel, exp_sel);
      end
    end
    btn_mode = 1'b1;
    cyc(); cyc();
    btn_mode = 1'b0;
    n_vec++;
    if (adjust_digit_sel !== 4'b0100) begin n_err++; $display("FAIL to_reenter_min got=%b exp=0100", adjust_digit_sel); end
    btn_down = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      exp_dec = (k == 1) || (k >= 5 && (k % 2) == 1);
      n_vec++;
      if (dec !== exp_dec || inc !== 1'b0) begin
        n_err++; $display("FAIL hold_down_k%0d dec/inc got=%b%b exp=%b0", k, dec, inc, exp_dec);
      end
    end
    n_vec++;
    if (adjust_digit_sel !== 4'b0100) begin n_err++; $display("FAIL hold_down_no_timeout got=%b exp=0100", adjust_digit_sel); end
    btn_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      n_vec++;
      if (inc !== 1'b0 || dec !== 1'b0) begin
        n_err++; $display("FAIL both_held_k%0d inc/dec got=%b%b exp=00", k, inc, dec);
      end
    end
    btn_up = 1'b0; btn_down = 1'b0;
    cyc();
    n_vec++;
    if (adjust_digit_sel !== 4'b0100 || inc !== 1'b0 || dec !== 1'b0) begin
      n_err++; $display("FAIL both_release sel=%b inc=%b dec=%b exp sel=0100 inc=0 dec=0", adjust_digit_sel, inc, dec);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_inc;
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    n_vec++;
    if (adjust_digit_sel !== 4'b0010) begin n_err++; $display("FAIL mid_enter_hour got=%b exp=0010", adjust_digit_sel); end
    btn_up = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      exp_inc = (k == 1) || (k == 5);
      n_vec++;
      if (inc !== exp_inc) begin n_err++; $display("FAIL mid_up_k%0d inc got=%b exp=%b", k, inc, exp_inc); end
    end
    rst = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h4D;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got=%b exp=0", cmd_ready); end
    cyc();
    n_vec++;
    if (adjust_digit_sel !== 4'b0000 || {clear, inc, dec, cmd_err} !== 4'b0000) begin
      n_err++; $display("FAIL mid_rst_out sel=%b pulses=%b exp sel=0000 pulses=0000", adjust_digit_sel, {clear, inc, dec, cmd_err});
    end
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold_ready got=%b exp=0", cmd_ready); end
    btn_up = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got=%b exp=1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0;
    n_vec++;
    if (adjust_digit_sel !== 4'b1000 || inc !== 1'b0) begin
      n_err++; $display("FAIL post_rst_cmd_m sel=%b inc=%b exp sel=1000 inc=0", adjust_digit_sel, inc);
    end
  endtask

  initial begin
    test_reset();
    test_mode();
    test_hold_up();
    test_commands();
    test_clear_vs_cmd();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/watch_ctrl.md
Name: watch_ctrl

Overview:
- Control unit for the watch datapath.
- Sequences the adjust-mode FSM and drives `adjust_digit_sel`, `clear`, `inc` and `dec` into the watch datapath.
- Arbitrates between local buttons (mode, clear, up/down with hold auto-repeat) and single-byte commands popped from the UART RX FIFO.
- Sits between the button debouncers / UART FIFO and the watch datapath.

Parameters:
- HOLD_TICKS, 500: `i_tick` count an up/down level must stay held before auto-repeat starts.
- REPEAT_TICKS, 100: `i_tick` count between auto-repeat pulses.
- TIMEOUT_TICKS, 10000: `i_tick` count of inactivity in an adjust state before returning to RUN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- i_tick  in  1  1 kHz one-cycle enable
- btn_mode  in  1  debounced one-cycle pulse
- btn_clear  in  1  debounced one-cycle pulse
- btn_up  in  1  debounced level
- btn_down  in  1  debounced level
- cmd_valid  in  1  FIFO not empty
- cmd_data  in  8  FIFO head byte (ASCII)
- cmd_ready  out  1  pop strobe to FIFO (combinational)
- adjust_digit_sel  out  4  one-hot adjust select; bit3 sec, bit2 min, bit1 hour, bit0 always 0
- clear  out  1  one-cycle clear pulse
- inc  out  1  one-cycle increment pulse
- dec  out  1  one-cycle decrement pulse
- cmd_err  out  1  one-cycle pulse when an unknown byte is consumed

Behaviour:
- Reset (`rst`=0 at a `clk` edge):
  - State RUN; `adjust_digit_sel`=0000; `clear`/`inc`/`dec`/`cmd_err`=0.
  - All counters cleared; up/down previous-level registers cleared.
- States and select encoding: RUN=0000, ADJ_SEC=1000, ADJ_MIN=0100, ADJ_HOUR=0010.
  - `adjust_digit_sel` is a registered decode of the state.
- Mode action: RUN→ADJ_SEC→ADJ_MIN→ADJ_HOUR→RUN.
- Return action: any state→RUN.
- Clear action: `clear`=1 for one cycle in any state; state unchanged.
- Up/down actions:
  - Only in ADJ states: `inc` or `dec`=1 for one cycle.
  - In RUN they are discarded; no pulse.
- Up/down button sources:
  - Rising edge of `btn_up`/`btn_down` gives an immediate action.
  - While the level stays held, the held-tick count is counted on `i_tick`. When it reaches HOLD_TICKS, one action fires, then one more every REPEAT_TICKS.
  - Release resets the counters.
  - Both levels high together: no up/down actions; both repeat counters held at 0.
- Commands: byte accepted when `cmd_valid` & `cmd_ready`.
  - 'M' (0x4D) = mode; 'C' (0x43) = clear; 'U' (0x55) = up; 'D' (0x44) = down; 'R' (0x52) = return.
  - Any other byte: consumed, `cmd_err`=1 next cycle, no action.
- Arbitration: one action per cycle. Priority: `btn_clear` > `btn_mode` > up/down edge > auto-repeat > command.
  - `cmd_ready` = NOT(any button action this cycle). A blocked command waits; it is never dropped.
  - Lower-priority button events in a conflicting cycle are dropped, except a held level, which keeps counting.
- Latency: action selected in cycle N; state, `adjust_digit_sel` and pulses are registered and visible in cycle N+1.
  - `inc`, `dec` and `clear` are mutually exclusive.
- Timeout: in ADJ states, count `i_tick` since the last action.
  - Any action, or either up/down level high, resets the count.
  - Count reaching TIMEOUT_TICKS forces RUN next cycle; count then resets.
  - In RUN the count is held at 0.
- Counter widths: `$clog2(param+1)` localparams; counters saturate and never wrap.
- Reset asserted mid-repeat or mid-command: all state is discarded.
  - The FIFO byte presented during reset is not popped (`cmd_ready`=0 while `rst`=0).

Decomposition:
- Package `watch_ctrl_pkg`:
  - State enum/encoding (RUN, ADJ_SEC, ADJ_MIN, ADJ_HOUR).
  - Select constants per state.
  - Command byte constants CMD_MODE, CMD_CLEAR, CMD_UP, CMD_DOWN, CMD_RUN.
- Sub-module `btn_repeat`:
  - Inputs: level, `i_tick`, inhibit. Output: one-cycle action pulse.
  - Contains edge detect plus hold/repeat counters; HOLD_TICKS/REPEAT_TICKS passed through.
  - Instantiated twice (up, down).

Test Plan (bench params HOLD_TICKS=4, REPEAT_TICKS=2, TIMEOUT_TICKS=20, `i_tick` every cycle):
- Reset, then 4 `btn_mode` pulses → `adjust_digit_sel` 1000, 0100, 0010, 0000, each changing one cycle after its pulse.
- In ADJ_SEC, hold `btn_up` for 10 cycles → `inc` at cycle+1 of the edge, then at held ticks 4, 6, 8; release → no further `inc`.
- In RUN, `cmd_data`='U' with `cmd_valid` → `cmd_ready`=1, no `inc`. Then 'M','D' → select 1000, one `dec` pulse. Then 0x7A → `cmd_err` pulse, state unchanged.
- `btn_clear` and `cmd_valid`('M') in the same cycle → `clear` pulse, `cmd_ready`=0 that cycle; 'M' accepted next cycle, select 1000.
- Enter ADJ_MIN, no activity → return to RUN (select 0000) exactly after 20 ticks. Repeat with `btn_down` held → no timeout, `dec` repeats; `btn_up`+`btn_down` both held → no pulses.
- Assert `rst`=0 mid-repeat in ADJ_HOUR with `cmd_valid` high → next cycle all outputs 0, state RUN, no FIFO pop during reset.
